// File: rtl/bcd_countdown_timer.sv
// M:SS BCD countdown timer: keypad shift-in entry, 1 Hz countdown with start/pause/resume/clear,
// and an auto-expiring DONE state. All outputs come straight from registers.
module bcd_countdown_timer #(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] bmin,
  output logic [3:0] bsec_tens,
  output logic [3:0] bsec_ones,
  output logic       running,
  output logic       paused,
  output logic       finished,
  output logic       done_pulse,
  output logic       key_err
);
  localparam int CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      bmin_q, bmin_d, tens_q, tens_d, ones_q, ones_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            kerr_q, kerr_d, dpulse_q, dpulse_d;
  logic            run_q, run_d, pause_q, pause_d, fin_q, fin_d;
  logic            is_zero, is_one;

  assign is_zero = (bmin_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign is_one  = (bmin_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bmin_q   <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      cnt_q    <= '0;
      kerr_q   <= 1'b0;
      dpulse_q <= 1'b0;
      run_q    <= 1'b0;
      pause_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bmin_q   <= bmin_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      cnt_q    <= cnt_d;
      kerr_q   <= kerr_d;
      dpulse_q <= dpulse_d;
      run_q    <= run_d;
      pause_q  <= pause_d;
      fin_q    <= fin_d;
    end
  end

  // One input acts per cycle, strictly in the order clear > stop > start > key_valid > tick.
  always_comb begin
    state_d  = state_q;
    bmin_d   = bmin_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    cnt_d    = cnt_q;
    kerr_d   = 1'b0;
    dpulse_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      bmin_d  = '0;
      tens_d  = '0;
      ones_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stop) begin
            bmin_d = '0;
            tens_d = '0;
            ones_d = '0;
          end else if (start) begin
            if (!is_zero) state_d = RUN;
          end else if (key_valid) begin
            // The ones digit moves into tens, so it must already be a legal tens value.
            if (key_digit <= 4'd9 && ones_q <= 4'd5) begin
              bmin_d = tens_q;
              tens_d = ones_q;
              ones_d = key_digit;
            end else begin
              kerr_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick && !start && !key_valid) begin
            if (is_one) begin
              ones_d   = '0;
              state_d  = DONE;
              cnt_d    = '0;
              dpulse_d = 1'b1;
            end else if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              if (tens_q != 4'd0) begin
                tens_d = tens_q - 4'd1;
              end else begin
                tens_d = 4'd5;
                bmin_d = bmin_q - 4'd1;
              end
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_d = IDLE;
            bmin_d  = '0;
            tens_d  = '0;
            ones_d  = '0;
          end else if (start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (tick && !start && !key_valid) begin
            if (cnt_q == CW'(DONE_TICKS - 1)) state_d = IDLE;
            else cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    run_d   = (state_d == RUN);
    pause_d = (state_d == PAUSE);
    fin_d   = (state_d == DONE);
  end

  assign bmin       = bmin_q;
  assign bsec_tens  = tens_q;
  assign bsec_ones  = ones_q;
  assign running    = run_q;
  assign paused     = pause_q;
  assign finished   = fin_q;
  assign done_pulse = dpulse_q;
  assign key_err    = kerr_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: a vector table replayed through a scoreboard queue,
// plus hand sequences for the long countdown and asynchronous reset.
module tb_bcd_countdown_timer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tick = 1'b0, key_valid = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [3:0] bmin, bsec_tens, bsec_ones;
  logic running, paused, finished, done_pulse, key_err;

  bcd_countdown_timer #(.DONE_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .bmin(bmin), .bsec_tens(bsec_tens),
    .bsec_ones(bsec_ones), .running(running), .paused(paused), .finished(finished),
    .done_pulse(done_pulse), .key_err(key_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] dig;
    logic [2:0]  fl;   // running, paused, finished
    logic        dp;
    logic        ke;
  } exp_t;

  typedef struct {
    logic       clr, stp, sta, kv, tk;
    logic [3:0] kd;
    exp_t       e;
    string      name;
  } vec_t;

  localparam logic [2:0] FI = 3'b000, FR = 3'b100, FP = 3'b010, FD = 3'b001;

  exp_t  sbq[$];
  string nameq[$];
  vec_t  tbl[$];
  int    checks = 0, errors = 0;

  function automatic exp_t got();
    return {bmin, bsec_tens, bsec_ones, running, paused, finished, done_pulse, key_err};
  endfunction

  function automatic vec_t V(input logic clr, stp, sta, kv, input logic [3:0] kd, input logic tk,
                             input logic [11:0] dig, input logic [2:0] fl, input logic dp, ke,
                             input string n);
    vec_t v;
    v.clr = clr; v.stp = stp; v.sta = sta; v.kv = kv; v.kd = kd; v.tk = tk;
    v.e = {dig, fl, dp, ke};
    v.name = n;
    return v;
  endfunction

  task automatic cmp(input string n, input exp_t g, input exp_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got dig=%h fl=%b dp=%b ke=%b exp dig=%h fl=%b dp=%b ke=%b",
               n, g.dig, g.fl, g.dp, g.ke, e.dig, e.fl, e.dp, e.ke);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    clear = v.clr; stop = v.stp; start = v.sta; key_valid = v.kv; key_digit = v.kd; tick = v.tk;
    sbq.push_back(v.e);
    nameq.push_back(v.name);
    @(posedge clk);
    #1;
    clear = 0; stop = 0; start = 0; key_valid = 0; key_digit = 0; tick = 0;
    cmp(nameq.pop_front(), got(), sbq.pop_front());
  endtask

  function automatic logic [11:0] sec2dig(input int s);
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  initial begin
    // Table for the main single-cycle behaviour, run after the long countdown below.
    tbl.push_back(V(0,0,0,1,4'd0,0,12'h000,FI,0,0,"k0"));
    tbl.push_back(V(0,0,0,1,4'd2,0,12'h002,FI,0,0,"k2"));
    tbl.push_back(V(0,0,1,0,4'd0,0,12'h002,FR,0,0,"start02"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h001,FR,0,0,"t001"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h000,FD,1,0,"t_done"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h000,FD,0,0,"done_t1"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h000,FD,0,0,"done_t2"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h000,FI,0,0,"done_t3_idle"));
    tbl.push_back(V(0,0,0,1,4'd1,0,12'h001,FI,0,0,"k1"));
    tbl.push_back(V(0,0,0,1,4'd0,0,12'h010,FI,0,0,"k0b"));
    tbl.push_back(V(0,0,1,0,4'd0,0,12'h010,FR,0,0,"start10"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h009,FR,0,0,"t009"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h008,FR,0,0,"t008"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h007,FR,0,0,"t007"));
    tbl.push_back(V(0,1,0,0,4'd0,1,12'h007,FP,0,0,"stop_tick"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h007,FP,0,0,"pause_t1"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h007,FP,0,0,"pause_t2"));
    tbl.push_back(V(0,0,1,0,4'd0,0,12'h007,FR,0,0,"resume"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h006,FR,0,0,"t006"));
    tbl.push_back(V(0,1,0,0,4'd0,0,12'h006,FP,0,0,"run_stop"));
    tbl.push_back(V(0,1,0,0,4'd0,0,12'h000,FI,0,0,"pause_stop"));
    tbl.push_back(V(0,0,0,1,4'd7,0,12'h007,FI,0,0,"k7"));
    tbl.push_back(V(0,0,0,1,4'd2,0,12'h007,FI,0,1,"k2_rej"));
    tbl.push_back(V(0,0,0,1,4'd12,0,12'h007,FI,0,1,"k12_rej"));
    tbl.push_back(V(1,0,0,0,4'd0,0,12'h000,FI,0,0,"clear"));
    tbl.push_back(V(0,0,1,0,4'd0,0,12'h000,FI,0,0,"start_zero"));
    tbl.push_back(V(0,0,0,1,4'd5,0,12'h005,FI,0,0,"k5"));
    tbl.push_back(V(0,1,0,0,4'd0,0,12'h000,FI,0,0,"idle_stop"));
    tbl.push_back(V(0,0,0,1,4'd1,0,12'h001,FI,0,0,"k1c"));
    tbl.push_back(V(0,0,1,0,4'd0,0,12'h001,FR,0,0,"start01"));
    tbl.push_back(V(0,0,0,1,4'd5,0,12'h001,FR,0,0,"run_key_ign"));
    tbl.push_back(V(0,0,0,0,4'd0,1,12'h000,FD,1,0,"t_done2"));
    tbl.push_back(V(0,0,1,0,4'd0,0,12'h000,FD,0,0,"done_start_ign"));
    tbl.push_back(V(0,1,0,0,4'd0,0,12'h000,FI,0,0,"done_stop"));

    repeat (2) @(posedge clk);
    #1 cmp("reset", got(), '0);
    @(negedge clk) rst_n = 1'b1;

    // Entry 1,3,0 then the long countdown across the minute boundary.
    apply(V(0,0,0,1,4'd1,0,12'h001,FI,0,0,"key1"));
    apply(V(0,0,0,1,4'd3,0,12'h013,FI,0,0,"key3"));
    apply(V(0,0,0,1,4'd0,0,12'h130,FI,0,0,"key0"));
    apply(V(0,0,1,0,4'd0,0,12'h130,FR,0,0,"start130"));
    for (int i = 1; i <= 31; i++)
      apply(V(0,0,0,0,4'd0,1,sec2dig(90 - i),FR,0,0,$sformatf("cd%0d", i)));
    apply(V(1,0,0,0,4'd0,0,12'h000,FI,0,0,"clear_cd"));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Asynchronous reset between edges while running at 0:45.
    apply(V(0,0,0,1,4'd4,0,12'h004,FI,0,0,"key4"));
    apply(V(0,0,0,1,4'd5,0,12'h045,FI,0,0,"key5"));
    apply(V(0,0,1,0,4'd0,0,12'h045,FR,0,0,"start45"));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 cmp("async_rst", got(), '0);
    @(negedge clk) rst_n = 1'b1;
    apply(V(0,0,0,0,4'd0,1,12'h000,FI,0,0,"post_rst_tick"));

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
